special_case_resolver: RTL
==========================

# special_case_resolver

Pipelined, handshaked special-operand classifier and fused-multiply-add special-result resolver for the MAC unit. It classifies operands A, B and C as zero, subnormal, normal, infinity, quiet NaN or signalling NaN. It then decides whether A×B±C has an IEEE-754 special result (NaN, infinity) that bypasses the main datapath, and raises the invalid-operation flag. It sits between operand fetch and the multiplier/aligner stage. It is parametrised in format width and tag width, and supports backpressure.

## Interface
Parameters:
- PARM_XLEN, 32, total operand width
- PARM_EXP, 8, exponent width
- PARM_MANT, 23, stored mantissa width (PARM_XLEN = 1 + PARM_EXP + PARM_MANT)
- PARM_TAG, 4, width of the opaque tag carried alongside each operation

Ports:
- clk_i  in  1  clock; all state on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- Flush_i  in  1  synchronous flush; drops all in-flight operations
- In_Valid_i  in  1  input operation valid
- In_Ready_o  out  1  block can accept an operation this cycle
- A_i, B_i, C_i  in  PARM_XLEN each  operands
- NegProd_i  in  1  negate product (fnmsub/fnmadd)
- NegAdd_i  in  1  negate addend (fmsub/fnmadd)
- Tag_i  in  PARM_TAG  pass-through tag
- Out_Valid_o  out  1  result valid
- Out_Ready_i  in  1  downstream accepts result
- Tag_o  out  PARM_TAG  tag of the presented result
- A_Class_o, B_Class_o, C_Class_o  out  3 each  class code: 0 zero, 1 subnormal, 2 normal, 3 inf, 4 qNaN, 5 sNaN
- Special_o  out  1  result fully determined by special-case logic
- Special_Result_o  out  PARM_XLEN  bypass result; valid when Special_o is 1
- NV_o  out  1  invalid-operation flag for this operation
- ProdZero_o  out  1  A or B is zero (datapath hint)

## Operation
- Classification from raw fields:
  - exp==0 & mant==0 → zero; exp==0 & mant!=0 → subnormal.
  - exp all-ones & mant==0 → inf.
  - exp all-ones & mant MSB=1 → qNaN; exp all-ones & mant MSB=0 & mant!=0 → sNaN.
  - Otherwise normal.
- Effective signs: Sp = A.sign ^ B.sign ^ NegProd_i; Sc = C.sign ^ NegAdd_i.
- Resolution priority (first match wins):
  1. Any operand NaN → canonical qNaN (sign 0, exp all-ones, mant MSB 1, rest 0). Special=1. NV=1 iff any operand is sNaN, or inf×0 is present.
  2. (A inf & B zero) or (A zero & B inf) → canonical qNaN, NV=1.
  3. Product inf, C inf, Sp != Sc → canonical qNaN, NV=1.
  4. Product inf → infinity with sign Sp, NV=0.
  5. C inf → infinity with sign Sc, NV=0.
  6. Otherwise Special=0, Special_Result=0, NV=0.
- Zero results and subnormal handling are left to the datapath. Special is never asserted for finite operands.

## Timing
- Two register stages:
  - S1 registers operands, classes, signs and tag.
  - S2 registers the resolution.
- Latency is 2 cycles from accepted input to Out_Valid_o. Throughput is 1 operation per cycle.
- Handshake:
  - A transfer occurs when Valid and Ready are both 1.
  - Out_Valid_o holds and outputs remain stable until accepted.
  - In_Ready_o = ~S1_valid | S1 advances.
  - S1 advances when ~S2_valid | Out_Ready_i.
  - In_Ready_o does not depend combinationally on In_Valid_i.
- Full: with both stages valid and Out_Ready_i=0, In_Ready_o=0 and nothing moves.
- Accept and retire in the same cycle are allowed with no bubble.
- Flush_i=1: both valids clear next cycle and any input offered that cycle is dropped. Flush has priority over acceptance.
- Reset (asserted at any time, including mid-operation) clears all pipeline state. All outputs read 0 during and after reset until new data arrives: Out_Valid_o, Special_o, NV_o, ProdZero_o, Tag_o, classes and Special_Result_o. In_Ready_o reads 1 after reset deassertion.

## Configuration
- SCD_FCLASS_EN defined: adds outputs A_FClass_o, B_FClass_o, C_FClass_o, each 10 bits.
  - Each is a RISC-V FCLASS one-hot mask, delivered aligned with Out_Valid_o: bit0 −inf, 1 −normal, 2 −subnormal, 3 −0, 4 +0, 5 +subnormal, 6 +normal, 7 +inf, 8 sNaN, 9 qNaN.
- Undefined: these ports and their registers are absent; all other behaviour is identical.

## Structure
- Shared header (MAC-wide): class-code constants, canonical-NaN construction, FCLASS bit positions.
- One sub-module, operand_classifier: combinational single-operand class decode plus sign. It is instantiated three times in S1.

## Test plan
- A=0x7F800000, B=0x00000000, C=0x3F800000 → Special=1, Result=0x7FC00000, NV=1, ProdZero=1, 2 cycles after accept.
- A=0x7F800000, B=0x3F800000, C=0xFF800000, NegProd=NegAdd=0 → Result=0x7FC00000, NV=1. The same with NegAdd=1 → Result=0x7F800000, NV=0.
- A=0x7F800001 (sNaN), B=C=0x3F800000 → A_Class=5, Result=0x7FC00000, NV=1. With A=0x7FC00000 → NV=0.
- A=0x00000001, B=0x3F800000, C=0x40000000 → A_Class=1, C_Class=2, Special=0, NV=0.
- Stream of 4 ops with Out_Ready_i low for 3 cycles → In_Ready_o falls after 2 accepts. No loss or duplication; tags emerge in order.
- Flush_i, or rst_ni pulse, with 2 ops in flight → Out_Valid_o=0 the next cycle. The next accepted op appears exactly 2 cycles later.

Source files
------------

// File: rtl/special_case_resolver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : special_case_resolver_pkg
// Description : Shared MAC header: operand class codes, FCLASS bit positions
//               and canonical quiet-NaN construction.
// Revision    : 1.0 - initial release
// ============================================================================
package special_case_resolver_pkg;

    typedef enum logic [2:0] {
        CLS_ZERO    = 3'd0,
        CLS_SUBNORM = 3'd1,
        CLS_NORMAL  = 3'd2,
        CLS_INF     = 3'd3,
        CLS_QNAN    = 3'd4,
        CLS_SNAN    = 3'd5
    } opClass_e;

    localparam int C_FCLASS_W       = 10;
    localparam int C_FC_NEG_INF     = 0;
    localparam int C_FC_NEG_NORMAL  = 1;
    localparam int C_FC_NEG_SUBNORM = 2;
    localparam int C_FC_NEG_ZERO    = 3;
    localparam int C_FC_POS_ZERO    = 4;
    localparam int C_FC_POS_SUBNORM = 5;
    localparam int C_FC_POS_NORMAL  = 6;
    localparam int C_FC_POS_INF     = 7;
    localparam int C_FC_SNAN        = 8;
    localparam int C_FC_QNAN        = 9;

    // Canonical qNaN: sign 0, exponent all-ones, only the mantissa MSB set.
    function automatic logic [63:0] canonNan(input int expW, input int mantW);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 64; i++) begin
            if ((i >= mantW - 1) && (i < mantW + expW)) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    function automatic logic [C_FCLASS_W-1:0] fclassMask(input opClass_e cls, input logic sign);
        logic [C_FCLASS_W-1:0] m;
        m = '0;
        case (cls)
            CLS_ZERO:    m[sign ? C_FC_NEG_ZERO    : C_FC_POS_ZERO]    = 1'b1;
            CLS_SUBNORM: m[sign ? C_FC_NEG_SUBNORM : C_FC_POS_SUBNORM] = 1'b1;
            CLS_NORMAL:  m[sign ? C_FC_NEG_NORMAL  : C_FC_POS_NORMAL]  = 1'b1;
            CLS_INF:     m[sign ? C_FC_NEG_INF     : C_FC_POS_INF]     = 1'b1;
            CLS_QNAN:    m[C_FC_QNAN] = 1'b1;
            CLS_SNAN:    m[C_FC_SNAN] = 1'b1;
            default:     m = '0;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/special_case_resolver_operand_classifier.sv
`default_nettype none
// ============================================================================
// Module      : special_case_resolver_operand_classifier
// Description : Combinational class decode and sign extraction of one operand.
// Revision    : 1.0 - initial release
// ============================================================================
module special_case_resolver_operand_classifier
    import special_case_resolver_pkg::*;
#(
    parameter int PARM_EXP  = 8,
    parameter int PARM_MANT = 23
) (
    input  logic [PARM_EXP+PARM_MANT:0] Operand_i,
    output opClass_e                    Class_o,
    output logic                        Sign_o
);

    logic [PARM_EXP-1:0]  w_exp;
    logic [PARM_MANT-1:0] w_mant;

    assign w_exp  = Operand_i[PARM_EXP+PARM_MANT-1:PARM_MANT];
    assign w_mant = Operand_i[PARM_MANT-1:0];
    assign Sign_o = Operand_i[PARM_EXP+PARM_MANT];

    always_comb begin
        Class_o = CLS_NORMAL;
        if (w_exp == '0) begin
            Class_o = (w_mant == '0) ? CLS_ZERO : CLS_SUBNORM;
        end else if (&w_exp) begin
            if (w_mant == '0) begin
                Class_o = CLS_INF;
            end else if (w_mant[PARM_MANT-1]) begin
                Class_o = CLS_QNAN;
            end else begin
                Class_o = CLS_SNAN;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/special_case_resolver.sv
`default_nettype none
// ============================================================================
// Module      : special_case_resolver
// Description : Two-stage handshaked FMA special-operand classifier/resolver.
//               Define SCD_FCLASS_EN to add per-operand RISC-V FCLASS masks.
// Revision    : 1.0 - initial release
// ============================================================================
module special_case_resolver
    import special_case_resolver_pkg::*;
#(
    parameter int PARM_XLEN = 32,
    parameter int PARM_EXP  = 8,
    parameter int PARM_MANT = 23,
    parameter int PARM_TAG  = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 Flush_i,
    input  logic                 In_Valid_i,
    output logic                 In_Ready_o,
    input  logic [PARM_XLEN-1:0] A_i,
    input  logic [PARM_XLEN-1:0] B_i,
    input  logic [PARM_XLEN-1:0] C_i,
    input  logic                 NegProd_i,
    input  logic                 NegAdd_i,
    input  logic [PARM_TAG-1:0]  Tag_i,
    output logic                 Out_Valid_o,
    input  logic                 Out_Ready_i,
    output logic [PARM_TAG-1:0]  Tag_o,
    output logic [2:0]           A_Class_o,
    output logic [2:0]           B_Class_o,
    output logic [2:0]           C_Class_o,
    output logic                 Special_o,
    output logic [PARM_XLEN-1:0] Special_Result_o,
    output logic                 NV_o,
    output logic                 ProdZero_o
`ifdef SCD_FCLASS_EN
    ,
    output logic [9:0]           A_FClass_o,
    output logic [9:0]           B_FClass_o,
    output logic [9:0]           C_FClass_o
`endif
);

    localparam logic [PARM_XLEN-1:0] C_CANON_NAN = PARM_XLEN'(canonNan(PARM_EXP, PARM_MANT));

    // ---------------- S1 input decode ----------------
    opClass_e w_aClass, w_bClass, w_cClass;
    logic     w_aSign, w_bSign, w_cSign;

    special_case_resolver_operand_classifier #(.PARM_EXP(PARM_EXP), .PARM_MANT(PARM_MANT)) u_clsA (
        .Operand_i(A_i), .Class_o(w_aClass), .Sign_o(w_aSign)
    );
    special_case_resolver_operand_classifier #(.PARM_EXP(PARM_EXP), .PARM_MANT(PARM_MANT)) u_clsB (
        .Operand_i(B_i), .Class_o(w_bClass), .Sign_o(w_bSign)
    );
    special_case_resolver_operand_classifier #(.PARM_EXP(PARM_EXP), .PARM_MANT(PARM_MANT)) u_clsC (
        .Operand_i(C_i), .Class_o(w_cClass), .Sign_o(w_cSign)
    );

    logic w_s1Advance;
    logic w_accept;
    logic r_s1Valid;
    logic r_s2Valid;

    assign w_s1Advance = ~r_s2Valid | Out_Ready_i;
    assign In_Ready_o  = ~r_s1Valid | w_s1Advance;
    assign w_accept    = In_Valid_i & In_Ready_o & ~Flush_i;

    opClass_e            r_s1AClass, r_s1BClass, r_s1CClass;
    logic                r_s1Sp, r_s1Sc;
    logic [PARM_TAG-1:0] r_s1Tag;
`ifdef SCD_FCLASS_EN
    logic                r_s1ASign, r_s1BSign, r_s1CSign;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1Valid  <= 1'b0;
            r_s1AClass <= CLS_ZERO;
            r_s1BClass <= CLS_ZERO;
            r_s1CClass <= CLS_ZERO;
            r_s1Sp     <= 1'b0;
            r_s1Sc     <= 1'b0;
            r_s1Tag    <= '0;
`ifdef SCD_FCLASS_EN
            r_s1ASign  <= 1'b0;
            r_s1BSign  <= 1'b0;
            r_s1CSign  <= 1'b0;
`endif
        end else begin
            if (Flush_i) begin
                r_s1Valid <= 1'b0;
            end else if (In_Ready_o) begin
                r_s1Valid <= In_Valid_i;
            end
            if (w_accept) begin
                r_s1AClass <= w_aClass;
                r_s1BClass <= w_bClass;
                r_s1CClass <= w_cClass;
                r_s1Sp     <= w_aSign ^ w_bSign ^ NegProd_i;
                r_s1Sc     <= w_cSign ^ NegAdd_i;
                r_s1Tag    <= Tag_i;
`ifdef SCD_FCLASS_EN
                r_s1ASign  <= w_aSign;
                r_s1BSign  <= w_bSign;
                r_s1CSign  <= w_cSign;
`endif
            end
        end
    end

    // ---------------- S2 resolution ----------------
    logic                 w_anyNan, w_anySnan, w_infTimesZero, w_prodInf, w_cInf;
    logic                 w_special, w_nv, w_prodZero;
    logic [PARM_XLEN-1:0] w_result;

    always_comb begin
        w_anyNan  = (r_s1AClass == CLS_QNAN) | (r_s1AClass == CLS_SNAN) |
                    (r_s1BClass == CLS_QNAN) | (r_s1BClass == CLS_SNAN) |
                    (r_s1CClass == CLS_QNAN) | (r_s1CClass == CLS_SNAN);
        w_anySnan = (r_s1AClass == CLS_SNAN) | (r_s1BClass == CLS_SNAN) | (r_s1CClass == CLS_SNAN);
        w_infTimesZero = ((r_s1AClass == CLS_INF) & (r_s1BClass == CLS_ZERO)) |
                         ((r_s1AClass == CLS_ZERO) & (r_s1BClass == CLS_INF));
        w_prodInf  = (r_s1AClass == CLS_INF) | (r_s1BClass == CLS_INF);
        w_cInf     = (r_s1CClass == CLS_INF);
        w_prodZero = (r_s1AClass == CLS_ZERO) | (r_s1BClass == CLS_ZERO);

        w_special = 1'b1;
        w_nv      = 1'b0;
        w_result  = C_CANON_NAN;
        // First match wins; NaN inputs still flag inf*0 as invalid.
        if (w_anyNan) begin
            w_nv = w_anySnan | w_infTimesZero;
        end else if (w_infTimesZero) begin
            w_nv = 1'b1;
        end else if (w_prodInf && w_cInf && (r_s1Sp != r_s1Sc)) begin
            w_nv = 1'b1;
        end else if (w_prodInf) begin
            w_result = {r_s1Sp, {PARM_EXP{1'b1}}, {PARM_MANT{1'b0}}};
        end else if (w_cInf) begin
            w_result = {r_s1Sc, {PARM_EXP{1'b1}}, {PARM_MANT{1'b0}}};
        end else begin
            w_special = 1'b0;
            w_result  = '0;
        end
    end

    opClass_e             r_s2AClass, r_s2BClass, r_s2CClass;
    logic [PARM_TAG-1:0]  r_s2Tag;
    logic                 r_s2Special, r_s2Nv, r_s2ProdZero;
    logic [PARM_XLEN-1:0] r_s2Result;
`ifdef SCD_FCLASS_EN
    logic [9:0]           r_s2AFClass, r_s2BFClass, r_s2CFClass;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s2Valid    <= 1'b0;
            r_s2AClass   <= CLS_ZERO;
            r_s2BClass   <= CLS_ZERO;
            r_s2CClass   <= CLS_ZERO;
            r_s2Tag      <= '0;
            r_s2Special  <= 1'b0;
            r_s2Nv       <= 1'b0;
            r_s2ProdZero <= 1'b0;
            r_s2Result   <= '0;
`ifdef SCD_FCLASS_EN
            r_s2AFClass  <= '0;
            r_s2BFClass  <= '0;
            r_s2CFClass  <= '0;
`endif
        end else begin
            if (Flush_i) begin
                r_s2Valid <= 1'b0;
            end else if (w_s1Advance) begin
                r_s2Valid <= r_s1Valid;
            end
            if (w_s1Advance && r_s1Valid && !Flush_i) begin
                r_s2AClass   <= r_s1AClass;
                r_s2BClass   <= r_s1BClass;
                r_s2CClass   <= r_s1CClass;
                r_s2Tag      <= r_s1Tag;
                r_s2Special  <= w_special;
                r_s2Nv       <= w_nv;
                r_s2ProdZero <= w_prodZero;
                r_s2Result   <= w_result;
`ifdef SCD_FCLASS_EN
                r_s2AFClass  <= fclassMask(r_s1AClass, r_s1ASign);
                r_s2BFClass  <= fclassMask(r_s1BClass, r_s1BSign);
                r_s2CFClass  <= fclassMask(r_s1CClass, r_s1CSign);
`endif
            end
        end
    end

    assign Out_Valid_o      = r_s2Valid;
    assign Tag_o            = r_s2Tag;
    assign A_Class_o        = r_s2AClass;
    assign B_Class_o        = r_s2BClass;
    assign C_Class_o        = r_s2CClass;
    assign Special_o        = r_s2Special;
    assign Special_Result_o = r_s2Result;
    assign NV_o             = r_s2Nv;
    assign ProdZero_o       = r_s2ProdZero;
`ifdef SCD_FCLASS_EN
    assign A_FClass_o       = r_s2AFClass;
    assign B_FClass_o       = r_s2BFClass;
    assign C_FClass_o       = r_s2CFClass;
`endif

endmodule
`default_nettype wire
